// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, FSM encoding and width helper
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest binary width able to hold every value of a DIGITS-digit BCD word.
  function automatic int unsigned min_bin_w(input int unsigned digits);
    longint unsigned limit;
    int unsigned w;
    limit = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      limit = limit * 10;
    end
    w = 0;
    while ((64'd1 << w) < limit) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_decoder_seq_if.sv
// rtl/bcd_decoder_seq_if.sv - input/output handshake bundle of the BCD decoder
interface bcd_decoder_seq_if #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W = 10
);

  logic [4*DIGITS-1:0] a;
  logic in_valid;
  logic in_ready;
  logic [BIN_W-1:0] out;
  logic err;
  logic out_valid;
  logic out_ready;

  modport master (
    output a, in_valid, out_ready,
    input  in_ready, out, err, out_valid
  );

  modport slave (
    input  a, in_valid, out_ready,
    output in_ready, out, err, out_valid
  );

endinterface

// File: rtl/bcd_mac10.sv
// rtl/bcd_mac10.sv - one decimal fold step: next_acc = acc*10 + digit
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 10
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [BCD_W-1:0] digit,
  output logic [BIN_W-1:0] next_acc,
  output logic digit_bad
);

  // Arithmetic mod 2^BIN_W gives the same low bits as the wider product truncated.
  assign next_acc  = (acc << 3) + (acc << 1) + BIN_W'(digit);
  assign digit_bad = (digit > BCD_MAX);

endmodule

// File: rtl/bcd_decoder_seq.sv
// rtl/bcd_decoder_seq.sv - sequential packed-BCD to binary decoder, MSD first
module bcd_decoder_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W = 10
) (
  input logic clk,
  input logic rst,
  bcd_decoder_seq_if.slave bus
);

  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SR_W = BCD_W * DIGITS;

  state_t state, state_next;
  logic [SR_W-1:0] sreg;
  logic [BIN_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic err_r;
  logic [BIN_W-1:0] next_acc;
  logic digit_bad;
  logic accept;
  logic last_digit;

  bcd_mac10 #(.BIN_W(BIN_W)) u_mac10 (
    .acc(acc),
    .digit(sreg[SR_W-1 -: BCD_W]),
    .next_acc(next_acc),
    .digit_bad(digit_bad)
  );

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last_digit = (cnt == CNT_W'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CONV;
      CONV:    if (last_digit) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      err_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= bus.a;
            acc   <= '0;
            cnt   <= '0;
            err_r <= 1'b0;
          end
        end
        CONV: begin
          acc   <= next_acc;
          err_r <= err_r | digit_bad;
          sreg  <= sreg << BCD_W;
          cnt   <= cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // acc and err_r are frozen in DONE, so out/err stay stable under backpressure.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.err       = err_r;
  assign bus.out       = ((state == DONE) && !err_r) ? acc : '0;

endmodule

// File: tb/tb_bcd_decoder_seq.sv
// tb/tb_bcd_decoder_seq.sv - directed self-checking bench for bcd_decoder_seq
module tb_bcd_decoder_seq;

  logic clk;
  logic rst;
  int vectors;
  int miscompares;

  bcd_decoder_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

  bcd_decoder_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_word(input logic [11:0] w, input int exp_out, input int exp_err, input int hold);
    int lat;
    bus.a = w;
    bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    step();
    bus.in_valid = 1'b0;
    chk("in_ready_busy", int'(bus.in_ready), 0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat - 1, 3);
    for (int h = 0; h < hold; h++) begin
      bus.a = 12'h111;
      bus.in_valid = 1'b1;
      chk("hold_out", int'(bus.out), exp_out);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("out", int'(bus.out), exp_out);
    chk("err", int'(bus.err), exp_err);
    step();
    chk("valid_drop", int'(bus.out_valid), 0);
    chk("in_ready_back", int'(bus.in_ready), 1);
  endtask

  initial begin
    logic [11:0] words [4];
    int exp_bin [4];
    int idx;
    int got;
    int last_t;
    int accept_now;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.a = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out", int'(bus.out), 0);
    chk("rst_err", int'(bus.err), 0);

    run_word(12'h123, 123, 0, 0);
    run_word(12'h000, 0, 0, 0);
    run_word(12'h999, 999, 0, 0);
    run_word(12'h1A3, 0, 1, 0);
    run_word(12'hFFF, 0, 1, 0);
    run_word(12'h042, 42, 0, 0);
    run_word(12'h256, 256, 0, 5);

    // Abort a conversion with rst on the second CONV edge.
    bus.a = 12'h789;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_out", int'(bus.out), 0);
    step();
    chk("abort_idle", int'(bus.out_valid), 0);
    run_word(12'h005, 5, 0, 0);

    // Back-to-back stream with in_valid held high.
    words[0] = 12'h001; exp_bin[0] = 1;
    words[1] = 12'h010; exp_bin[1] = 10;
    words[2] = 12'h100; exp_bin[2] = 100;
    words[3] = 12'h998; exp_bin[3] = 998;
    idx = 0;
    got = 0;
    last_t = 0;
    bus.out_ready = 1'b1;
    bus.a = words[0];
    bus.in_valid = 1'b1;
    for (int t = 0; t < 60 && got < 4; t++) begin
      if (bus.out_valid) begin
        chk("stream_out", int'(bus.out), exp_bin[got]);
        chk("stream_err", int'(bus.err), 0);
        if (got > 0) chk("stream_spacing", t - last_t, 5);
        last_t = t;
        got++;
      end
      accept_now = int'(bus.in_ready && bus.in_valid);
      step();
      if (accept_now != 0) begin
        idx++;
        if (idx < 4) bus.a = words[idx];
        else bus.in_valid = 1'b0;
      end
    end
    chk("stream_count", got, 4);
    bus.in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
